// File: rtl/demux_stream_router.sv
// Registered 1-to-NUM_CH valid/ready demultiplexer with unicast and broadcast routing.
// Each channel owns a one-entry holding register; out-of-range selects are dropped and counted.
module demux_stream_router #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 8,
   parameter int SEL_W  = $clog2(NUM_CH),
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic                     in_bcast,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

   logic [NUM_CH-1:0]              valid_q, valid_d;
   logic [NUM_CH-1:0][DATA_W-1:0]  data_q, data_d;
   logic [CNT_W-1:0]               drop_q, drop_d;

   logic [NUM_CH-1:0] free;
   logic [NUM_CH-1:0] load;
   logic              sel_legal;
   logic              sel_free;
   logic              ready_c;
   logic              accept;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      free      = ~valid_q | out_ready;
      sel_legal = ({1'b0, in_sel} < NUM_CH_L);
      sel_free  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (in_sel == SEL_W'(i)) sel_free = free[i];
      end

      // Ready never looks at in_valid; an illegal select is always swallowed.
      if (!rst_n)         ready_c = 1'b0;
      else if (in_bcast)  ready_c = &free;
      else if (!sel_legal) ready_c = 1'b1;
      else                ready_c = sel_free;

      accept = in_valid & ready_c;

      load    = '0;
      valid_d = valid_q;
      data_d  = data_q;
      for (int i = 0; i < NUM_CH; i++) begin
         load[i]    = accept & (in_bcast | (in_sel == SEL_W'(i)));
         valid_d[i] = load[i] | (valid_q[i] & ~out_ready[i]);
         if (load[i]) data_d[i] = in_data;
      end

      drop_d = drop_q;
      if (accept && !in_bcast && !sel_legal) drop_d = sat_inc(drop_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         drop_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         drop_q  <= drop_d;
      end
   end

   assign in_ready  = ready_c;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_stream_router.sv
// Directed bench for demux_stream_router: vector table plus hand-written multi-cycle sequences.
module tb_demux_stream_router;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_bcast;
   logic [7:0]  in_data;
   logic [2:0]  in_sel;
   logic [7:0]  out_valid, out_ready;
   logic [63:0] out_data;
   logic [7:0]  drop_cnt;

   logic        v6, rdy6, bc6;
   logic [7:0]  d6;
   logic [2:0]  sel6;
   logic [5:0]  ov6, ordy6;
   logic [47:0] od6;
   logic [1:0]  drop6;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   demux_stream_router u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .drop_cnt(drop_cnt)
   );

   demux_stream_router #(.NUM_CH(6), .CNT_W(2)) u6 (
      .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(rdy6),
      .in_data(d6), .in_sel(sel6), .in_bcast(bc6),
      .out_valid(ov6), .out_ready(ordy6), .out_data(od6),
      .drop_cnt(drop6)
   );

   typedef struct {
      logic       v;
      logic [2:0] sel;
      logic       bc;
      logic [7:0] d;
      logic [7:0] ordy;
      logic       exp_rdy;
      logic [7:0] exp_ov;
      logic [2:0] chk_ch;
      logic [7:0] exp_d;
      logic [7:0] exp_drop;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mkv(logic v, logic [2:0] sel, logic bc, logic [7:0] d,
                                logic [7:0] ordy, logic exp_rdy, logic [7:0] exp_ov,
                                logic [2:0] chk_ch, logic [7:0] exp_d, logic [7:0] exp_drop);
      vec_t t;
      t.v = v; t.sel = sel; t.bc = bc; t.d = d; t.ordy = ordy;
      t.exp_rdy = exp_rdy; t.exp_ov = exp_ov; t.chk_ch = chk_ch;
      t.exp_d = exp_d; t.exp_drop = exp_drop;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] sel, input logic bc,
                        input logic [7:0] d, input logic [7:0] ordy);
      in_valid = v; in_sel = sel; in_bcast = bc; in_data = d; out_ready = ordy;
   endtask

   task automatic apply(input vec_t t, input int idx);
      drive(t.v, t.sel, t.bc, t.d, t.ordy);
      #1;
      chk($sformatf("vec%0d in_ready", idx), 64'(in_ready), 64'(t.exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", idx), 64'(out_valid), 64'(t.exp_ov));
      chk($sformatf("vec%0d out_data[%0d]", idx, t.chk_ch),
          64'(out_data[t.chk_ch*8 +: 8]), 64'(t.exp_d));
      chk($sformatf("vec%0d drop_cnt", idx), 64'(drop_cnt), 64'(t.exp_drop));
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      v6 = 1'b0; sel6 = 3'd0; bc6 = 1'b0; d6 = 8'h00; ordy6 = 6'h00;

      // Scenario 1: unicast sweep, consumers always ready
      for (int i = 0; i < 8; i++)
         tbl.push_back(mkv(1'b1, 3'(i), 1'b0, 8'hA0 + 8'(i), 8'hFF, 1'b1,
                           8'(1 << i), 3'(i), 8'hA0 + 8'(i), 8'h00));
      tbl.push_back(mkv(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 3'd7, 8'hA7, 8'h00));
      // Scenario 2: backpressure on channel 3
      tbl.push_back(mkv(1'b1, 3'd3, 1'b0, 8'h11, 8'hF7, 1'b1, 8'h08, 3'd3, 8'h11, 8'h00));
      tbl.push_back(mkv(1'b1, 3'd3, 1'b0, 8'h22, 8'hF7, 1'b0, 8'h08, 3'd3, 8'h11, 8'h00));
      tbl.push_back(mkv(1'b1, 3'd3, 1'b0, 8'h22, 8'hFF, 1'b1, 8'h08, 3'd3, 8'h22, 8'h00));
      tbl.push_back(mkv(1'b0, 3'd3, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 3'd3, 8'h22, 8'h00));
      // Scenario 3: broadcast blocked by stalled channel 5, then released
      tbl.push_back(mkv(1'b1, 3'd5, 1'b0, 8'h33, 8'hDF, 1'b1, 8'h20, 3'd5, 8'h33, 8'h00));
      tbl.push_back(mkv(1'b1, 3'd0, 1'b1, 8'h5A, 8'hDF, 1'b0, 8'h20, 3'd5, 8'h33, 8'h00));
      tbl.push_back(mkv(1'b1, 3'd0, 1'b1, 8'h5A, 8'hDF, 1'b0, 8'h20, 3'd0, 8'hA0, 8'h00));
      tbl.push_back(mkv(1'b1, 3'd0, 1'b1, 8'h5A, 8'hFF, 1'b1, 8'hFF, 3'd5, 8'h5A, 8'h00));
      tbl.push_back(mkv(1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hFF, 3'd2, 8'h5A, 8'h00));

      repeat (2) @(posedge clk);
      #2;
      chk("reset out_valid", 64'(out_valid), 64'h0);
      chk("reset out_data", out_data, 64'h0);
      chk("reset drop_cnt", 64'(drop_cnt), 64'h0);
      chk("reset in_ready", 64'(in_ready), 64'h0);
      chk("reset drop6", 64'(drop6), 64'h0);
      chk("reset od6", 64'(od6), 64'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[k]) apply(tbl[k], k);

      // every channel should now hold the broadcast word, stalled
      for (int i = 0; i < 8; i++)
         chk($sformatf("bcast ch%0d data", i), 64'(out_data[i*8 +: 8]), 64'h5A);
      apply(mkv(1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 3'd6, 8'h5A, 8'h00), 100);

      // Scenario 4: illegal select on the 6-channel instance, saturating 2-bit counter
      v6 = 1'b1; sel6 = 3'd7; d6 = 8'hC3; ordy6 = 6'h3F;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("drop%0d in_ready6", k), 64'(rdy6), 64'h1);
         @(posedge clk); #1;
         chk($sformatf("drop%0d out_valid6", k), 64'(ov6), 64'h0);
         chk($sformatf("drop%0d drop_cnt6", k), 64'(drop6), (k < 3) ? 64'(k + 1) : 64'd3);
      end
      v6 = 1'b0;

      // Scenario 5: asynchronous reset while channels 0, 2, 4 are held
      apply(mkv(1'b1, 3'd0, 1'b0, 8'h10, 8'h00, 1'b1, 8'h01, 3'd0, 8'h10, 8'h00), 200);
      apply(mkv(1'b1, 3'd2, 1'b0, 8'h12, 8'h00, 1'b1, 8'h05, 3'd2, 8'h12, 8'h00), 201);
      apply(mkv(1'b1, 3'd4, 1'b0, 8'h14, 8'h00, 1'b1, 8'h15, 3'd4, 8'h14, 8'h00), 202);
      drive(1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst out_valid", 64'(out_valid), 64'h0);
      chk("midrst out_data", out_data, 64'h0);
      chk("midrst in_ready", 64'(in_ready), 64'h0);
      chk("midrst drop6", 64'(drop6), 64'h0);
      #1 rst_n = 1'b1;
      apply(mkv(1'b1, 3'd2, 1'b0, 8'h77, 8'hFF, 1'b1, 8'h04, 3'd2, 8'h77, 8'h00), 203);

      // Scenario 6: back-to-back stream into channel 1
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 3'd1, 1'b0, 8'h40 + 8'(k), 8'hFF);
         #1;
         chk($sformatf("b2b%0d in_ready", k), 64'(in_ready), 64'h1);
         @(posedge clk); #1;
         chk($sformatf("b2b%0d out_valid", k), 64'(out_valid), 64'h02);
         chk($sformatf("b2b%0d out_data1", k), 64'(out_data[15:8]), 64'(8'h40 + 8'(k)));
      end
      drive(1'b0, 3'd1, 1'b0, 8'h00, 8'hFF);
      @(posedge clk); #1;
      chk("b2b drained", 64'(out_valid), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
- Parametrised, registered 1-to-NUM_CH demultiplexer for valid/ready streams.
- Each input word is routed to one output channel selected by in_sel, or to all channels in broadcast mode.
- Every output channel has its own one-entry holding register and handles backpressure independently.
- Sits between a single stream producer and NUM_CH independent consumers; replaces the combinational 1x8 select-demux wherever flow control is needed.

Parameters:
- DATA_W, 8, width of one data word.
- NUM_CH, 8, number of output channels; legal range 2..256, need not be a power of two.
- SEL_W, $clog2(NUM_CH), width of the select field (derived; not overridden).
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  router can accept the input word this cycle.
- in_data  in  DATA_W  input word.
- in_sel  in  SEL_W  destination channel index (unicast).
- in_bcast  in  1  1 = deliver the word to all channels; in_sel is ignored.
- out_valid  out  NUM_CH  bit i: channel i holds a word.
- out_ready  in  NUM_CH  bit i: consumer i accepts this cycle.
- out_data  out  NUM_CH*DATA_W  channel i word on bits [i*DATA_W +: DATA_W].
- drop_cnt  out  CNT_W  count of words discarded because in_sel was out of range.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, drop_cnt = 0. While rst_n is low, in_ready = 0.
- Channel i is free when out_valid[i] = 0 or (out_valid[i] & out_ready[i]); the draining case allows full throughput.
- in_ready is combinational and does not depend on in_valid:
  - in_bcast = 1: in_ready = 1 only when all channels are free.
  - in_bcast = 0 and in_sel < NUM_CH: in_ready = free[in_sel].
  - in_bcast = 0 and in_sel >= NUM_CH: in_ready = 1.
- Accept = in_valid & in_ready.
- Unicast accept, legal sel: the channel in_sel register loads in_data and out_valid[in_sel] is 1 on the next cycle (latency 1). Other channels are untouched.
- Broadcast accept: all NUM_CH registers load in_data, and all out_valid bits are 1 next cycle. Broadcast is all-or-nothing; there is never a partial fan-out.
- Unicast accept, illegal sel (in_sel >= NUM_CH): the word is discarded and no out_valid changes.
  - drop_cnt increments by 1 and saturates at 2^CNT_W-1; it never wraps.
  - This case cannot occur when NUM_CH is a power of two.
- Channel drain: out_valid[i] & out_ready[i] with no new load into channel i → out_valid[i] = 0 next cycle. out_data[i] keeps its last value; it is not cleared.
- Simultaneous drain and load on the same channel: the new word replaces the old, and out_valid stays 1. The old word counts as delivered.
- Hold rule: while out_valid[i] = 1 and out_ready[i] = 0, out_data[i] and out_valid[i] stay stable.
- out_ready[i] while out_valid[i] = 0: no effect.
- No ordering guarantee between different channels. Per-channel order equals input acceptance order.
- Reset asserted mid-operation: all held words are lost, outputs return to reset values immediately, and drop_cnt clears.
- Throughput: one word per cycle when targets drain every cycle.

Test Plan:
1. Unicast sweep (NUM_CH=8): with out_ready all 1, send in_data=8'hA0+i, in_sel=i for i=0..7 on consecutive cycles → exactly out_valid[i] is 1 on the cycle after each accept, with out_data[i]=A0+i. in_ready stays 1 throughout and drop_cnt=0.
2. Backpressure: out_ready[3]=0, send two words 8'h11 then 8'h22 to sel=3 → first accepted; in_ready=0 for the second; out_data[3] holds 11. Raise out_ready[3] for one cycle → 22 accepted the same cycle and out_data[3]=22 the next cycle.
3. Broadcast with a stalled channel: channel 5 full and out_ready[5]=0; send in_bcast=1, data 8'h5A → in_ready=0 and no channel loads. Release channel 5 → word accepted, and all 8 out_valid bits are 1 with out_data=5A on every channel.
4. Illegal select (NUM_CH=6, CNT_W=2): send five words with in_sel=7 → each accepted with no out_valid change; drop_cnt goes 1,2,3,3,3 (saturated).
5. Reset mid-operation: fill channels 0, 2 and 4 with out_ready=0, then pulse rst_n low between clock edges → out_valid=0 and out_data=0 asynchronously, before the next edge. After release, a unicast to sel=2 behaves as in scenario 1.
6. Back-to-back same channel: out_ready[1]=1 constantly; stream 16 words to sel=1 → one accept per cycle with no bubbles, and out_data[1] matches the input sequence delayed by 1 cycle.
